// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell adds two WIDTH-bit operands LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // Bit 0 of the encoding is busy and bit 1 is done, so both decode glitch-free.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             fa_sum, fa_co;
  logic [WIDTH-1:0] sum_msb;
  logic [WIDTH-1:0] acc_shift;

  full_adder u_fa (
    .a  (sh_a_q[0]),
    .b  (sh_b_q[0]),
    .ci (carry_q),
    .s  (fa_sum),
    .co (fa_co)
  );

  // Sum bit enters at the MSB; built this way so WIDTH=1 needs no special case.
  always_comb begin
    sum_msb = '0;
    sum_msb[WIDTH-1] = fa_sum;
    acc_shift = (acc_q >> 1) | sum_msb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_a_d  = op_a;
          sh_b_d  = op_b;
          carry_d = cin;
`ifdef SERIAL_ADD_SUB_EN
          // Two's-complement subtract: invert B and inject a carry of one.
          if (sub) begin
            sh_b_d  = ~op_b;
            carry_d = 1'b1;
          end
`endif
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        acc_d   = acc_shift;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          result_d = acc_shift;
          cout_d   = fa_co;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = state_q[0];
    done   = state_q[1];
    result = result_q;
    cout   = cout_q;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances on a shared clock.
// Subtract vectors run only when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cin;
  logic [7:0] op_a, op_b;
  logic       busy, done, cout;
  logic [7:0] result;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub;
  logic       sub1;
`endif

  logic       start1, cin1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1;
  logic [0:0] result1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .cin    (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub    (sub),
`endif
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start1),
    .op_a   (a1),
    .op_b   (b1),
    .cin    (cin1),
`ifdef SERIAL_ADD_SUB_EN
    .sub    (sub1),
`endif
    .busy   (busy1),
    .done   (done1),
    .result (result1),
    .cout   (cout1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits up to 20 edges for done; returns edge count from the reference edge (0 = timeout).
  task automatic wait_done(input int first_k, output int k_done);
    k_done = 0;
    for (int k = first_k; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        k_done = k;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] exp_r, input logic exp_c);
    int kd;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    wait_done(1, kd);
    chk({tag, "_latency"}, 32'(kd), 32'd8);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    chk({tag, "_result"}, 32'(result), 32'(exp_r));
    chk({tag, "_cout"}, 32'(cout), 32'(exp_c));
    @(posedge clk); #1;
    chk({tag, "_done_cleared"}, 32'(done), 32'd0);
    chk({tag, "_busy_cleared"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int kd;
    rst = 1'b1; start = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    start1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0; sub1 = 1'b0;
`endif
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_busy_w1", 32'(busy1), 32'd0);
    #12 rst = 1'b0;

    run_op("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op("ff_plus_1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("a5_5a_c1", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

    // Start held high; operand change mid-run must not disturb the captured pair.
    @(negedge clk);
    op_a = 8'h12; op_b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("held_busy_e0", 32'(busy), 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    op_a = 8'hFF; op_b = 8'hFF;
    wait_done(3, kd);
    chk("held_latency", 32'(kd), 32'd8);
    chk("held_result", 32'(result), 32'h46);
    chk("held_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    chk("held_busy_e9", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("held_busy_e10", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(1, kd);
    chk("held2_latency", 32'(kd), 32'd8);
    chk("held2_result", 32'(result), 32'hFE);
    chk("held2_cout", 32'(cout), 32'd1);

    // Asynchronous reset between E4 and E5 aborts the operation.
    @(negedge clk);
    op_a = 8'h33; op_b = 8'h44; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    #1 rst = 1'b0;
    kd = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done || busy) kd++;
    end
    chk("abort_quiet", 32'(kd), 32'd0);
    run_op("after_abort", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

    // WIDTH=1 instance completes one edge after the start edge.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("w1_busy_e0", 32'(busy1), 32'd1);
    chk("w1_done_e0", 32'(done1), 32'd0);
    @(posedge clk); #1;
    chk("w1_done_e1", 32'(done1), 32'd1);
    chk("w1_result", 32'(result1), 32'd1);
    chk("w1_cout", 32'(cout1), 32'd1);
    @(posedge clk); #1;
    chk("w1_done_e2", 32'(done1), 32'd0);
    chk("w1_busy_e2", 32'(busy1), 32'd0);

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    run_op("sub_5_7", 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0);
    run_op("sub_7_5", 8'h07, 8'h05, 1'b0, 8'h02, 1'b1);
    sub = 1'b0;
    run_op("sub_off", 8'h07, 8'h05, 1'b0, 8'h0C, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
